// File: rtl/pec_package.sv
// ============================================================================
//  Module      : pec_package
//  Description : Shared types, constants and helpers for the PEC cluster
//                scheduler (FSM state encoding, round-robin pick, popcount).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pec_package;

  localparam int PERF_CNT_W = 32;
  localparam int PEC_MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } pec_sched_fsm_state_t;

  // Returns {found, index}: first set bit of idle at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [PEC_MAX_CH-1:0] idle,
                                         input logic [2:0]            ptr,
                                         input int                    n);
    logic [3:0] res;
    int         cand;
    res = 4'd0;
    for (int i = PEC_MAX_CH - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % n;
      if (i < n && idle[cand[2:0]]) res = {1'b1, cand[2:0]};
    end
    return res;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, v[i]};
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pec_job_fifo.sv
// ============================================================================
//  Module      : pec_job_fifo
//  Description : Power-of-two job descriptor FIFO with synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pec_job_fifo #(
  parameter int JOB_DEPTH = 4,
  parameter int JOB_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [JOB_W-1:0]           data_i,
  input  logic                       pop_i,
  output logic [JOB_W-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(JOB_DEPTH):0] level_o
);

  localparam int c_aw = $clog2(JOB_DEPTH);

  logic [JOB_W-1:0] r_mem [JOB_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (c_aw+1)'(JOB_DEPTH));
  assign empty_o = (r_count == '0);
  // A flush wins over any push or pop in the same cycle.
  assign w_push  = push_i & ~full_o & ~flush_i;
  assign w_pop   = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign level_o = r_count;

endmodule

`default_nettype wire

// File: rtl/pec_cluster_sched.sv
// ============================================================================
//  Module      : pec_cluster_sched
//  Description : Round-robin job dispatcher for NUM_PEC accelerator channels.
//                Optional busy-cycle counters enabled by PEC_SCHED_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pec_cluster_sched
  import pec_package::*;
#(
  parameter int NUM_PEC   = 2,
  parameter int JOB_DEPTH = 4,
  parameter int JOB_W     = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 enable_i,
  input  logic                                 flush_i,
  input  logic                                 job_valid_i,
  output logic                                 job_ready_o,
  input  logic [JOB_W-1:0]                     job_i,
  output logic [NUM_PEC-1:0]                   pec_start_o,
  output logic [NUM_PEC-1:0][JOB_W-1:0]        pec_job_o,
  input  logic [NUM_PEC-1:0]                   pec_done_i,
  output logic [NUM_PEC-1:0]                   busy_o,
  output logic [$clog2(JOB_DEPTH):0]           q_level_o,
  output logic [15:0]                          jobs_done_o,
  output logic                                 irq_o,
  output logic                                 err_o,
  input  logic                                 clear_err_i,
  output logic [NUM_PEC-1:0][PERF_CNT_W-1:0]   perf_busy_cycles_o
);

  localparam int c_ch_w = (NUM_PEC > 1) ? $clog2(NUM_PEC) : 1;

  pec_sched_fsm_state_t r_state;
  pec_sched_fsm_state_t w_state_nxt;

  logic                          r_alive;
  logic [NUM_PEC-1:0]            r_busy;
  logic [NUM_PEC-1:0]            r_start;
  logic [NUM_PEC-1:0][JOB_W-1:0] r_job;
  logic [15:0]                   r_jobs_done;
  logic                          r_err;
  logic                          r_irq;
  logic                          r_done_pend;
  logic [c_ch_w-1:0]             r_rr_ptr;

  logic                          w_push;
  logic                          w_full;
  logic                          w_empty;
  logic [JOB_W-1:0]              w_head;
  logic                          w_can_issue;
  logic                          w_dispatch;
  logic [PEC_MAX_CH-1:0]         w_idle8;
  logic [PEC_MAX_CH-1:0]         w_done_ok8;
  logic [3:0]                    w_pick;
  logic [c_ch_w-1:0]             w_grant_idx;
  logic [c_ch_w-1:0]             w_ptr_nxt;
  logic [NUM_PEC-1:0]            w_grant_oh;
  logic [NUM_PEC-1:0]            w_done_ok;
  logic [NUM_PEC-1:0]            w_done_bad;
  logic                          w_irq_cond;

  // Ready is held low until the first clock after reset so every output reads 0 in reset.
  assign job_ready_o = r_alive & ~w_full;
  assign w_push      = job_valid_i & job_ready_o;

  pec_job_fifo #(
    .JOB_DEPTH (JOB_DEPTH),
    .JOB_W     (JOB_W)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (job_i),
    .pop_i   (w_dispatch),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (q_level_o)
  );

  always_comb begin
    w_idle8              = '0;
    w_idle8[NUM_PEC-1:0] = ~r_busy;
  end

  assign w_pick      = rr_pick(w_idle8, 3'(r_rr_ptr), NUM_PEC);
  assign w_grant_idx = c_ch_w'(w_pick[2:0]);
  assign w_grant_oh  = NUM_PEC'(1) << w_grant_idx;
  assign w_ptr_nxt   = (w_grant_idx == c_ch_w'(NUM_PEC - 1)) ? '0 : w_grant_idx + c_ch_w'(1);
  assign w_can_issue = ~w_empty & enable_i & w_pick[3] & ~flush_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (flush_i)          w_state_nxt = DRAIN;
        else if (w_can_issue) w_state_nxt = ISSUE;
      end
      ISSUE:   w_state_nxt = flush_i ? DRAIN : IDLE;
      DRAIN: begin
        if (!flush_i && (r_busy == '0)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; the pop and channel load happen on the edge into ISSUE
  always_comb begin
    w_dispatch = 1'b0;
    case (r_state)
      IDLE:    w_dispatch = w_can_issue;
      default: w_dispatch = 1'b0;
    endcase
  end

  assign w_done_ok  = pec_done_i & r_busy;
  assign w_done_bad = pec_done_i & ~r_busy;

  always_comb begin
    w_done_ok8              = '0;
    w_done_ok8[NUM_PEC-1:0] = w_done_ok;
  end

  assign w_irq_cond = w_empty & (r_busy == '0) & r_done_pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alive     <= 1'b0;
      r_busy      <= '0;
      r_start     <= '0;
      r_job       <= '0;
      r_jobs_done <= '0;
      r_err       <= 1'b0;
      r_irq       <= 1'b0;
      r_done_pend <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_alive     <= 1'b1;
      r_start     <= w_dispatch ? w_grant_oh : '0;
      r_busy      <= (r_busy & ~w_done_ok) | (w_dispatch ? w_grant_oh : '0);
      r_jobs_done <= r_jobs_done + 16'(popcount8(w_done_ok8));
      if (w_dispatch) begin
        r_job[w_grant_idx] <= w_head;
        r_rr_ptr           <= w_ptr_nxt;
      end
      if (|w_done_bad)      r_err <= 1'b1;
      else if (clear_err_i) r_err <= 1'b0;
      r_irq <= w_irq_cond;
      if (w_irq_cond)       r_done_pend <= 1'b0;
      else if (|w_done_ok)  r_done_pend <= 1'b1;
    end
  end

  assign pec_start_o = r_start;
  assign pec_job_o   = r_job;
  assign busy_o      = r_busy;
  assign jobs_done_o = r_jobs_done;
  assign irq_o       = r_irq;
  assign err_o       = r_err;

`ifdef PEC_SCHED_PERF_EN
  for (genvar g = 0; g < NUM_PEC; g++) begin : g_perf
    logic [PERF_CNT_W-1:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                       r_cnt <= '0;
      else if (r_busy[g] && (r_cnt != '1)) r_cnt <= r_cnt + PERF_CNT_W'(1);
    end
    assign perf_busy_cycles_o[g] = r_cnt;
  end
`else
  assign perf_busy_cycles_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pec_cluster_sched.sv
// ============================================================================
//  Module      : tb_pec_cluster_sched
//  Description : Scoreboard bench for pec_cluster_sched (NUM_PEC=2, depth 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pec_cluster_sched;

  localparam int NUM_PEC   = 2;
  localparam int JOB_DEPTH = 4;
  localparam int JOB_W     = 32;
`ifdef PEC_SCHED_PERF_EN
  localparam logic [63:0] EXP_PERF0 = 64'd10;
`else
  localparam logic [63:0] EXP_PERF0 = 64'd0;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          enable;
  logic                          flush;
  logic                          job_valid;
  logic                          job_ready;
  logic [JOB_W-1:0]              job;
  logic [NUM_PEC-1:0]            pec_start;
  logic [NUM_PEC-1:0][JOB_W-1:0] pec_job;
  logic [NUM_PEC-1:0]            pec_done;
  logic [NUM_PEC-1:0]            busy;
  logic [2:0]                    q_level;
  logic [15:0]                   jobs_done;
  logic                          irq;
  logic                          err;
  logic                          clear_err;
  logic [NUM_PEC-1:0][31:0]      perf;

  typedef struct packed {
    logic [1:0]  oh;
    logic [31:0] job;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   irq_cnt     = 0;

  always #5 clk = ~clk;

  pec_cluster_sched #(
    .NUM_PEC   (NUM_PEC),
    .JOB_DEPTH (JOB_DEPTH),
    .JOB_W     (JOB_W)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .enable_i           (enable),
    .flush_i            (flush),
    .job_valid_i        (job_valid),
    .job_ready_o        (job_ready),
    .job_i              (job),
    .pec_start_o        (pec_start),
    .pec_job_o          (pec_job),
    .pec_done_i         (pec_done),
    .busy_o             (busy),
    .q_level_o          (q_level),
    .jobs_done_o        (jobs_done),
    .irq_o              (irq),
    .err_o              (err),
    .clear_err_i        (clear_err),
    .perf_busy_cycles_o (perf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_start(input logic [1:0] oh, input logic [31:0] d);
    sb.push_back('{oh: oh, job: d});
  endtask

  task automatic push(input logic [31:0] d);
    job_valid = 1'b1;
    job       = d;
    check("push_ready", 64'(job_ready), 64'd1);
    tick(1);
    job_valid = 1'b0;
  endtask

  task automatic done(input int ch);
    pec_done[ch] = 1'b1;
    tick(1);
    pec_done = '0;
  endtask

  // Monitor: every start pulse is matched against the oldest expected dispatch.
  always @(negedge clk) begin
    if (rst_n) begin
      if (irq) irq_cnt++;
      if (pec_start != '0) begin
        if (sb.size() == 0) begin
          check("start_unexpected", 64'(pec_start), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("start_ch", 64'(pec_start), 64'(mon_e.oh));
          check("start_job", 64'(mon_e.oh[1] ? pec_job[1] : pec_job[0]), 64'(mon_e.job));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    flush     = 1'b0;
    job_valid = 1'b0;
    job       = '0;
    pec_done  = '0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(job_ready), 64'd0);
    check("rst_level", 64'(q_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_jobs_done", 64'(jobs_done), 64'd0);
    check("rst_err_irq", 64'({err, irq, pec_start}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Three jobs onto two channels, third waits for ch0's done.
    enable = 1'b1;
    expect_start(2'b01, 32'hA);
    expect_start(2'b10, 32'hB);
    expect_start(2'b01, 32'hC);
    push(32'hA);
    check("start_not_early", 64'(pec_start), 64'd0);
    push(32'hB);
    check("start_latency2", 64'(pec_start), 64'd1);
    push(32'hC);
    tick(2);
    check("busy_both", 64'(busy), 64'd3);
    check("level_one", 64'(q_level), 64'd1);
    done(0);
    check("busy_clear", 64'(busy), 64'd2);
    check("jobs_done_1", 64'(jobs_done), 64'd1);
    tick(1);
    check("start_after_done", 64'(pec_start), 64'd1);
    done(1);
    done(0);
    tick(3);
    check("a_jobs_done", 64'(jobs_done), 64'd3);
    check("a_irq_cnt", 64'(irq_cnt), 64'd1);
    check("a_busy_idle", 64'(busy), 64'd0);

    // Fill the queue while dispatch is disabled, then let it drain.
    enable = 1'b0;
    push(32'h10);
    push(32'h11);
    push(32'h12);
    push(32'h13);
    check("full_ready_low", 64'(job_ready), 64'd0);
    check("level_full", 64'(q_level), 64'd4);
    check("no_dispatch_disabled", 64'(busy), 64'd0);
    job_valid = 1'b1;
    job       = 32'h14;
    tick(3);
    check("level_hold_full", 64'(q_level), 64'd4);
    expect_start(2'b10, 32'h10);
    expect_start(2'b01, 32'h11);
    expect_start(2'b10, 32'h12);
    expect_start(2'b01, 32'h13);
    expect_start(2'b10, 32'h14);
    enable = 1'b1;
    tick(1);
    check("ready_after_pop", 64'(job_ready), 64'd1);
    tick(1);
    job_valid = 1'b0;
    check("level_refill", 64'(q_level), 64'd4);
    tick(4);
    done(1);
    tick(3);
    done(0);
    tick(3);
    done(1);
    tick(3);
    done(0);
    done(1);
    tick(3);
    check("b_level_empty", 64'(q_level), 64'd0);
    check("b_jobs_done", 64'(jobs_done), 64'd8);
    check("b_irq_cnt", 64'(irq_cnt), 64'd2);

    // Flush with three queued and two running.
    expect_start(2'b01, 32'h20);
    expect_start(2'b10, 32'h21);
    for (int i = 0; i < 5; i++) push(32'h20 + 32'(i));
    check("c_level_3", 64'(q_level), 64'd3);
    check("c_busy_both", 64'(busy), 64'd3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_level", 64'(q_level), 64'd0);
    tick(2);
    check("drain_busy_hold", 64'(busy), 64'd3);
    done(0);
    tick(2);
    check("drain_one_left", 64'(busy), 64'd2);
    done(1);
    tick(3);
    check("c_jobs_done", 64'(jobs_done), 64'd10);
    check("c_irq_once", 64'(irq_cnt), 64'd3);

    // Flush drops a concurrent push; no dispatch until the drain completes.
    expect_start(2'b01, 32'h30);
    push(32'h30);
    tick(3);
    check("d_busy_ch0", 64'(busy), 64'd1);
    job_valid = 1'b1;
    job       = 32'h31;
    flush     = 1'b1;
    tick(1);
    job_valid = 1'b0;
    flush     = 1'b0;
    check("flush_drops_push", 64'(q_level), 64'd0);
    expect_start(2'b10, 32'h32);
    push(32'h32);
    tick(3);
    check("drain_no_dispatch", 64'(q_level), 64'd1);
    done(0);
    tick(4);
    check("drain_exit_dispatch", 64'(busy), 64'd2);
    done(1);
    tick(3);
    check("d_jobs_done", 64'(jobs_done), 64'd12);
    check("d_irq_cnt", 64'(irq_cnt), 64'd4);

    // Stray done on an idle channel.
    done(1);
    check("err_set", 64'(err), 64'd1);
    check("err_jobs_same", 64'(jobs_done), 64'd12);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("err_cleared", 64'(err), 64'd0);

    // Busy-cycle counter on a 10-cycle job, then reset in the middle of a job.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    expect_start(2'b01, 32'h40);
    push(32'h40);
    tick(1);
    check("f_start_ch0", 64'(pec_start), 64'd1);
    tick(9);
    done(0);
    check("f_busy_idle", 64'(busy), 64'd0);
    check("f_perf0", 64'(perf[0]), EXP_PERF0);
    check("f_jobs_done", 64'(jobs_done), 64'd1);
    expect_start(2'b10, 32'h41);
    push(32'h41);
    tick(4);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy_start", 64'({busy, pec_start}), 64'd0);
    check("mid_rst_job", 64'(pec_job), 64'd0);
    check("mid_rst_perf", 64'(perf), 64'd0);
    check("mid_rst_misc", 64'({job_ready, q_level, jobs_done, irq, err}), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    done(1);
    check("post_rst_done_err", 64'(err), 64'd1);
    check("post_rst_jobs", 64'(jobs_done), 64'd0);
    tick(2);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pec_cluster_sched.md
PEC_CLUSTER_SCHED -- requirements
Module: pec_cluster_sched

Interface
REQ-001 SHALL have parameter NUM_PEC, default 2: number of PEC accelerator channels, legal range 1..8.
REQ-002 SHALL have parameter JOB_DEPTH, default 4: job-queue entries, power of two, at least 2.
REQ-003 SHALL have parameter JOB_W, default 32: job descriptor width in bits.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable_i, input, 1 bit: dispatch enable.
REQ-007 SHALL have port flush_i, input, 1 bit: single-cycle pulse that discards queued jobs.
REQ-008 SHALL have ports job_valid_i (input, 1), job_ready_o (output, 1) and job_i (input, JOB_W): job push handshake.
REQ-009 SHALL have ports pec_start_o (output, NUM_PEC) and pec_job_o (output, NUM_PEC x JOB_W): per-channel start pulse and held descriptor.
REQ-010 SHALL have port pec_done_i, input, NUM_PEC bits: per-channel completion pulse.
REQ-011 SHALL have ports busy_o (output, NUM_PEC), q_level_o (output, clog2(JOB_DEPTH)+1), jobs_done_o (output, 16), irq_o (output, 1), err_o (output, 1) and clear_err_i (input, 1).
REQ-012 SHALL have port perf_busy_cycles_o, output, NUM_PEC x 32 bits: per-channel busy-cycle count.

Function
REQ-013 SHALL accept a push when job_valid_i and job_ready_o are both high; job_ready_o SHALL equal not-full.
REQ-014 SHALL use an FSM with states IDLE, ISSUE and DRAIN.
REQ-015 SHALL move IDLE->ISSUE when the queue is non-empty, enable_i is high and at least one channel is idle.
REQ-016 In ISSUE, SHALL pop the head job, load pec_job_o[c], pulse pec_start_o[c] for exactly one cycle, set busy_o[c], then return to IDLE.
REQ-017 SHALL select channel c round-robin among idle channels, searching from one past the last granted channel.
REQ-018 SHALL assert pec_start_o two cycles after a push into an empty queue when a channel is idle and enable_i is high.
REQ-019 SHALL hold pec_job_o[c] stable until the next start pulse on channel c.
REQ-020 On pec_done_i[c] with busy_o[c] high, SHALL clear busy_o[c] next cycle and increment jobs_done_o, wrapping at 16 bits; the channel is eligible from the following cycle.
REQ-021 On pec_done_i[c] with busy_o[c] low, SHALL ignore the pulse and set err_o, which is sticky until clear_err_i.
REQ-022 On a push and a pop in the same cycle, SHALL leave q_level_o unchanged; a push while full SHALL be impossible because job_ready_o is low.
REQ-023 flush_i SHALL empty the queue next cycle and enter DRAIN; in-flight jobs continue to run.
REQ-024 SHALL leave DRAIN for IDLE when all busy_o bits are clear; no dispatch occurs in DRAIN; a flush concurrent with a push drops the pushed job.
REQ-025 SHALL pulse irq_o for one cycle when the queue is empty, all channels are idle and at least one done was counted since the previous irq.
REQ-026 When enable_i is low, SHALL suppress dispatch while the queue still accepts jobs.

Reset
REQ-027 rst_ni low SHALL asynchronously set the FSM to IDLE and empty the queue.
REQ-028 rst_ni low SHALL clear all outputs, counters and the round-robin pointer; the pointer starts at channel 0.
REQ-029 Reset mid-job SHALL abandon the job; done pulses arriving after reset SHALL set err_o.

Configuration
REQ-030 With PEC_SCHED_PERF_EN defined, each perf_busy_cycles_o[c] SHALL increment every cycle busy_o[c] is high, saturating at all-ones and cleared only by reset.
REQ-031 Without PEC_SCHED_PERF_EN, perf_busy_cycles_o SHALL be tied to zero and no counter flops are inferred.

Structure
REQ-032 pec_package SHALL hold pec_sched_fsm_state_t (IDLE/ISSUE/DRAIN) and the perf counter width constant.
REQ-033 The job queue SHALL be a sub-module named pec_job_fifo, parametrised by JOB_DEPTH and JOB_W.

Verification
REQ-034 NUM_PEC=2: push jobs 0xA, 0xB, 0xC -> 0xA starts on ch0 and 0xB on ch1; 0xC starts on ch0 the cycle after ch0 is eligible following its done.
REQ-035 Push 5 jobs into a depth-4 queue with enable_i=0 -> job_ready_o low after the 4th, q_level_o=4; enable_i=1 -> queue drains.
REQ-036 Flush with 3 queued and 2 busy -> q_level_o=0, FSM in DRAIN; two dones -> IDLE, jobs_done_o=2, irq_o pulses once.
REQ-037 pec_done_i[1] while ch1 idle -> err_o=1, jobs_done_o unchanged; clear_err_i -> err_o=0.
REQ-038 With PEC_SCHED_PERF_EN, a 10-cycle job on ch0 -> perf_busy_cycles_o[0]=10; rst_ni low mid-job -> all outputs 0.
